// File: rtl/riscv_muldiv_if.sv
// Handshake bundle between the EX stage and the iterative multiply-divide unit.
// The pipeline drives the master side and the unit drives the slave side.
interface riscv_muldiv_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              start;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [TAG_W-1:0]  rd_tag_in;
  logic              flush;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  rd_tag_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_tag_in, flush,
    input  ready, done, result, rd_tag_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_tag_in, flush,
    output ready, done, result, rd_tag_out
  );
endinterface

// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply-divide unit: one op at a time, DATA_W-cycle
// shift-add multiply or restoring divide, with a one-cycle path for divide corner cases.
module riscv_muldiv #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic          clk,
  input  logic          reset,
  riscv_muldiv_if.slave bus
);
  // state | meaning
  // IDLE  | nothing in flight, ready to accept
  // CALC  | iterating on latched magnitudes, ready low
  // DONE  | result valid, done pulses, back-to-back accept allowed

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [2:0]          op_q,      op_d;
  logic [TAG_W-1:0]    tag_q,     tag_d;
  logic [TAG_W-1:0]    rd_tag_q,  rd_tag_d;
  logic [DATA_W-1:0]   result_q,  result_d;
  logic [2*DATA_W-1:0] acc_q,     acc_d;
  logic [DATA_W-1:0]   opb_q,     opb_d;
  logic                neg_q,     neg_d;
  logic                rem_neg_q, rem_neg_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, fast_path, accept;
  logic [DATA_W-1:0] a_mag, b_mag, fast_res;

  // Operand decode for a new request; only consumed on accept.
  always_comb begin
    a_signed  = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed  = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg     = a_signed & bus.rs1_data[DATA_W-1];
    b_neg     = b_signed & bus.rs2_data[DATA_W-1];
    a_mag     = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag     = b_neg ? -bus.rs2_data : bus.rs2_data;
    div_zero  = bus.funct3[2] & (bus.rs2_data == '0);
    div_ovf   = bus.funct3[2] & ~bus.funct3[0] &
                (bus.rs1_data == MIN_NEG) & (bus.rs2_data == '1);
    fast_path = div_zero | div_ovf;
    if (div_zero) begin
      fast_res = bus.funct3[1] ? bus.rs1_data : '1;
    end else begin
      fast_res = bus.funct3[1] ? '0 : bus.rs1_data;
    end
  end

  logic [DATA_W:0]     mul_sum, div_shl, div_diff;
  logic [2*DATA_W-1:0] mul_step, div_step, step, prod;
  logic [DATA_W-1:0]   quo, rem, fin_res;

  // One iteration of the datapath; acc holds {partial/remainder, multiplier/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[DATA_W-1:1]};
    div_shl  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff = div_shl - {1'b0, opb_q};
    if (div_diff[DATA_W]) begin
      div_step = {div_shl[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end else begin
      div_step = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end
    step = op_q[2] ? div_step : mul_step;
    prod = neg_q ? -step : step;
    quo  = step[DATA_W-1:0];
    rem  = step[2*DATA_W-1:DATA_W];
    if (op_q[2]) begin
      if (op_q[1]) begin
        fin_res = rem_neg_q ? -rem : rem;
      end else begin
        fin_res = neg_q ? -quo : quo;
      end
    end else if (op_q[1:0] == 2'b00) begin
      fin_res = prod[DATA_W-1:0];
    end else begin
      fin_res = prod[2*DATA_W-1:DATA_W];
    end
  end

  assign accept = bus.start & bus.ready & ~bus.flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    rd_tag_d  = rd_tag_q;
    result_d  = result_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          op_d      = bus.funct3;
          tag_d     = bus.rd_tag_in;
          acc_d     = {{DATA_W{1'b0}}, a_mag};
          opb_d     = b_mag;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          if (fast_path) begin
            state_d  = DONE;
            result_d = fast_res;
            rd_tag_d = bus.rd_tag_in;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            result_d = fin_res;
            rd_tag_d = tag_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      rd_tag_q  <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      rd_tag_q  <= rd_tag_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign bus.ready      = (state_q != CALC);
  assign bus.done       = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.rd_tag_out = rd_tag_q;
endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (DATA_W=32): directed corner cases plus
// random ops compared against a plain-arithmetic RV32M reference.
module tb_riscv_muldiv;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] last_res;
  logic [4:0]  last_tag;

  riscv_muldiv_if #(.DATA_W(32), .TAG_W(5)) bus ();

  riscv_muldiv #(.DATA_W(32), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    bus.start     = 1'b1;
    bus.funct3    = f;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_tag_in = tag;
  endtask

  // Called at a negedge; issues one op and checks latency, result, tag, ready.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
    logic [31:0] exp;
    bit          fast;
    bit          rdy_low;
    int          lat;
    int          w;
    exp  = model(f, a, b);
    fast = f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    w = 0;
    while (!bus.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready_before"}, 64'(bus.ready), 64'd1);
    drive(f, a, b, tag);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), fast ? 64'd1 : 64'd33);
    chk({name, "_result"}, 64'(bus.result), 64'(exp));
    chk({name, "_tag"}, 64'(bus.rd_tag_out), 64'(tag));
    if (!fast) chk({name, "_ready_low"}, 64'(rdy_low), 64'd1);
    last_res = exp;
    last_tag = tag;
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          d;
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_tag_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_tag", 64'(bus.rd_tag_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd11);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd12);
    run_op("div0", 3'd4, 32'h64, 32'd0, 5'd13);
    run_op("rem0", 3'd6, 32'h64, 32'd0, 5'd14);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

    // Flush ten cycles into a divide, with a competing start in the same cycle.
    @(negedge clk);
    drive(3'd4, 32'd1000, 32'd3, 5'd20);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    drive(3'd4, 32'd55, 32'd0, 5'd21);
    @(negedge clk);
    chk("flush_ready", 64'(bus.ready), 64'd1);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_result", 64'(bus.result), 64'(last_res));
    chk("flush_tag", 64'(bus.rd_tag_out), 64'(last_tag));
    @(negedge clk);
    chk("flush_start_idle", 64'(bus.done), 64'd0);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("flush_no_late_done", 64'(bus.done), 64'd0);

    // Back-to-back: start held through the first op's DONE cycle.
    drive(3'd5, 32'd1000, 32'd9, 5'd3);
    @(posedge clk);
    @(negedge clk);
    drive(3'd0, 32'hFFFF_FFFF, 32'd12345, 5'd4);
    d = 1;
    while (!bus.done && d < 40) begin
      @(negedge clk);
      d++;
    end
    chk("b2b_first_lat", 64'(d), 64'd33);
    chk("b2b_first_res", 64'(bus.result), 64'(model(3'd5, 32'd1000, 32'd9)));
    @(negedge clk);
    bus.start = 1'b0;
    d = 1;
    while (!bus.done && d < 40) begin
      @(negedge clk);
      d++;
    end
    chk("b2b_gap", 64'(d), 64'd33);
    chk("b2b_second_res", 64'(bus.result), 64'(model(3'd0, 32'hFFFF_FFFF, 32'd12345)));
    chk("b2b_second_tag", 64'(bus.rd_tag_out), 64'd4);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op("rand", rf, ra, rb, 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_no_done", 64'(bus.done), 64'd0);
    run_op("post_rst", 3'd7, 32'hFFFF_FFFF, 32'd10, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative, parametrised RV32M/RV64M multiply-divide unit for the pipelined RISC-V core. It sits beside the EX-stage ALU, accepts one M-extension operation at a time from the pipeline, and holds the pipeline via its ready signal while it iterates. It returns the result tagged with its destination register for write-back. Width and tag size are generic, so the same block serves 32- and 64-bit cores.

## Interface
Parameters:
- DATA_W, 32: operand/result width (even, ≥8)
- TAG_W, 5: destination-register tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- funct3  in  3  RISC-V M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  DATA_W  operand A / dividend
- rs2_data  in  DATA_W  operand B / divisor
- rd_tag_in  in  TAG_W  destination register
- flush  in  1  kill the in-flight op (branch/jump redirect)
- ready  out  1  unit can accept (state IDLE or DONE)
- done  out  1  one-cycle pulse; result and rd_tag_out valid
- result  out  DATA_W  op result; held until the next accept
- rd_tag_out  out  TAG_W  tag of the completed op

## Operation
- States: IDLE, CALC, DONE.
- Reset (asynchronous, active-low): state IDLE, ready=1, done=0, result=0, rd_tag_out=0, iteration counter 0.
- Accept = start && ready && !flush.
  - On accept, latch funct3 and tag.
  - Latch operand magnitudes and result-sign flag.
  - Signedness: MUL/MULH/DIV/REM both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
- Multiply: unsigned shift-add over DATA_W iterations into a 2·DATA_W accumulator, then conditionally negated.
  - MUL returns the low DATA_W bits.
  - MULH, MULHSU and MULHU return the high DATA_W bits.
- Divide: restoring shift-subtract over DATA_W iterations on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Fast path (skips CALC, IDLE/DONE→DONE directly):
  - Divisor = 0:
    - DIV/DIVU quotient = all ones.
    - REM/REMU remainder = rs1_data.
  - Signed overflow (DIV/REM, rs1 = 1 followed by zeros, rs2 = all ones):
    - quotient = rs1_data, remainder = 0.
- Transitions:
  - IDLE→CALC on accept (normal path), IDLE→DONE on accept (fast path).
  - CALC→DONE when the counter reaches DATA_W−1.
  - DONE→CALC or DONE on accept (back-to-back), DONE→IDLE otherwise.
- done=1 exactly in DONE. result and rd_tag_out are registered on CALC→DONE or fast-path entry and are otherwise stable.
- start while ready=0 is ignored; the requester must hold start until it sees ready.
- flush:
  - In CALC: next state IDLE; result and rd_tag_out are unchanged; no done pulse.
  - In DONE: done still pulses this cycle (the op already completed).
  - In any state: the same-cycle start is not accepted.
- Reset mid-CALC aborts immediately with no done pulse.

## Timing
- Accept at edge T, normal path: CALC spans T+1…T+DATA_W; done=1 in cycle T+DATA_W+1 (33 cycles for DATA_W=32).
- Accept at edge T, fast path: done=1 in cycle T+1.
- ready=0 throughout CALC and 1 in IDLE/DONE; it is a function of registered state only.
- Back-to-back: an accept in the DONE cycle yields no idle bubble; the second op's done arrives DATA_W+1 cycles later.
- No combinational path from start, funct3, rs1_data or rs2_data to any output.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), tag 5 → done exactly 33 cycles after accept, result 0xFFFFFFEB, rd_tag_out 5; ready=0 for 32 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Fast path:
  - DIV 0x64 / 0 → 0xFFFFFFFF with done one cycle after accept.
  - REM 0x64 / 0 → 0x64.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- flush asserted 10 cycles into a DIV → unit is IDLE next cycle, no done pulse, result keeps its prior value. A start asserted with flush in the same cycle is ignored.
- Back-to-back start held through the DONE cycle → second done exactly 33 cycles after the first.
- reset asserted asynchronously mid-CALC → ready=1, done=0, result=0 before the next clock edge.
